mpsub_seq: RTL and testbench
============================

MPSUB_SEQ -- requirements
Module: mpsub_seq

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the word width of the subtractor stage the block drives.
REQ-002 Parameter WORDS, default 4, SHALL set the number of words per operand (WORDS >= 2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL flag that in_a/in_b/in_signed are valid.
REQ-006 in_ready  output  1  SHALL flag that the block accepts a new operation.
REQ-007 in_a, in_b  input  WIDTH*WORDS each  SHALL carry the minuend and subtrahend; word 0 is the LS word.
REQ-008 in_signed  input  1  SHALL select signed (1) or unsigned (0) flag semantics.
REQ-009 sub_a, sub_b  output  WIDTH each  SHALL drive the current word to the subtractor stage; sub_b carries the raw subtrahend word, and the stage inverts it.
REQ-010 sub_cin  output  1  and  sub_signed_en  output  1  SHALL drive the subtractor's carry-in and signed enable.
REQ-011 sub_out  input  WIDTH, sub_cout, sub_zero, sub_neg, sub_ovf  input  1 each  SHALL be the subtractor's combinational result and flags for the driven word.
REQ-012 out_valid  output  1  and  out_ready  input  1  SHALL form the result handshake.
REQ-013 out_diff  output  WIDTH*WORDS, out_borrow, out_zero, out_neg, out_ovf  output  1 each  SHALL carry the full difference and flags.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: in_valid=1 SHALL latch in_a, in_b and in_signed, clear the word index to 0 and enter RUN.
REQ-017 RUN: each cycle SHALL drive word idx on sub_a/sub_b and store sub_out into result word idx, so one word is processed per cycle.
REQ-018 sub_cin SHALL be 1 for word 0, and for word k>0 SHALL be the registered sub_cout of word k-1.
REQ-019 sub_signed_en SHALL be the latched in_signed on word WORDS-1 only, and 0 on every other word.
REQ-020 The zero accumulator SHALL be set to 1 on accept and ANDed with sub_zero on every word.
REQ-021 On word WORDS-1 the block SHALL register: out_borrow = ~sub_cout, out_neg = sub_neg, out_ovf = sub_ovf; the FSM then enters DONE.
REQ-022 Latency: a transfer accepted at edge T SHALL produce out_valid=1 after edge T+WORDS+1.
REQ-023 DONE SHALL hold all outputs stable until out_ready=1, then return to IDLE.
REQ-024 in_ready SHALL NOT be 1 in the cycle a result is consumed: the earliest next accept is one cycle after the DONE->IDLE transition.
REQ-025 In IDLE and DONE, sub_a, sub_b, sub_cin and sub_signed_en SHALL be driven to 0.
REQ-026 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-027 The word index SHALL count 0..WORDS-1 and SHALL NOT wrap within an operation.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, clear the word index, operand registers and carry, and set out_diff=0, out_borrow=0, out_zero=0, out_neg=0, out_ovf=0, out_valid=0 and in_ready=0 while asserted.
REQ-029 in_ready SHALL be 1 from the first rising edge after rst_n deasserts.
REQ-030 Reset during RUN or DONE SHALL abort the operation with no out_valid pulse, and the aborted operation SHALL NOT be resumed.

Verification (WIDTH=8, WORDS=2, subtractor stage connected)
REQ-031 Borrow chain: a=0x0100, b=0x0001, unsigned -> out_diff=0x00FF, out_borrow=0, out_zero=0; out_valid 3 cycles after accept.
REQ-032 Underflow: a=0x0000, b=0x0001, signed -> out_diff=0xFFFF, out_borrow=1, out_neg=1, out_ovf=0.
REQ-033 Signed overflow: a=0x8000, b=0x0001, signed -> out_diff=0x7FFF, out_ovf=1, out_neg=0; the same operands unsigned -> out_ovf=0.
REQ-034 Zero: a=b=0x1234 -> out_diff=0x0000, out_zero=1; a=0x1234, b=0x0034 -> out_zero=0, because the LS word alone is zero.
REQ-035 Backpressure: out_ready=0 for 5 cycles -> outputs held stable and in_ready=0; in_ready=1 one cycle after the out_ready handshake.
REQ-036 Reset mid-RUN: rst_n pulsed low at word 1 -> out_valid never asserts and in_ready=1 after release; the next operation is correct.

Source files
------------

// File: rtl/mpsub_seq.sv
// Multi-word sequential subtractor controller: feeds one WIDTH-bit word per cycle
// to an external subtractor stage, chains the carry and collects difference and flags.
module mpsub_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*WORDS-1:0]   in_a,
  input  logic [WIDTH*WORDS-1:0]   in_b,
  input  logic                     in_signed,
  output logic [WIDTH-1:0]         sub_a,
  output logic [WIDTH-1:0]         sub_b,
  output logic                     sub_cin,
  output logic                     sub_signed_en,
  input  logic [WIDTH-1:0]         sub_out,
  input  logic                     sub_cout,
  input  logic                     sub_zero,
  input  logic                     sub_neg,
  input  logic                     sub_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*WORDS-1:0]   out_diff,
  output logic                     out_borrow,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_ovf
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  a_q, b_q, diff_q;
  logic [IW-1:0] idx;
  logic          signed_q, carry_q, alive_q, fin_q;
  logic          zero_q, borrow_q, neg_q, ovf_q;

  always_comb begin
    state_nx      = state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    sub_a         = '0;
    sub_b         = '0;
    sub_cin       = 1'b0;
    sub_signed_en = 1'b0;
    case (state)
      IDLE: begin
        // alive_q keeps in_ready low until the first edge after reset release
        in_ready = alive_q;
        if (in_valid && alive_q) state_nx = RUN;
      end
      RUN: begin
        if (!fin_q) begin
          sub_a         = a_q[int'(idx)*WIDTH +: WIDTH];
          sub_b         = b_q[int'(idx)*WIDTH +: WIDTH];
          sub_cin       = (idx == '0) ? 1'b1 : carry_q;
          sub_signed_en = (idx == LAST) && signed_q;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      alive_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx      <= '0;
      signed_q <= 1'b0;
      carry_q  <= 1'b0;
      fin_q    <= 1'b0;
      zero_q   <= 1'b0;
      borrow_q <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      state   <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid && alive_q) begin
            a_q      <= in_a;
            b_q      <= in_b;
            signed_q <= in_signed;
            idx      <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            fin_q    <= 1'b0;
          end
        end
        RUN: begin
          // the last word sets fin_q; one settle cycle follows before DONE
          if (!fin_q) begin
            diff_q[int'(idx)*WIDTH +: WIDTH] <= sub_out;
            carry_q <= sub_cout;
            zero_q  <= zero_q & sub_zero;
            if (idx == LAST) begin
              borrow_q <= ~sub_cout;
              neg_q    <= sub_neg;
              ovf_q    <= sub_ovf;
              fin_q    <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_diff   = diff_q;
  assign out_borrow = borrow_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_mpsub_seq.sv
// Scoreboard bench for mpsub_seq (WIDTH=8, WORDS=2) with a behavioural subtractor stage.
module tb_mpsub_seq;

  localparam int W  = 8;
  localparam int WD = 2;
  localparam int N  = W * WD;
  localparam int P  = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_signed;
  logic [N-1:0] in_a, in_b, out_diff;
  logic [W-1:0] sub_a, sub_b, sub_out;
  logic         sub_cin, sub_signed_en, sub_cout, sub_zero, sub_neg, sub_ovf;
  logic         out_valid, out_ready, out_borrow, out_zero, out_neg, out_ovf;

  always #(P/2) clk = ~clk;

  mpsub_seq #(.WIDTH(W), .WORDS(WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .sub_a(sub_a), .sub_b(sub_b), .sub_cin(sub_cin), .sub_signed_en(sub_signed_en),
    .sub_out(sub_out), .sub_cout(sub_cout), .sub_zero(sub_zero),
    .sub_neg(sub_neg), .sub_ovf(sub_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_zero(out_zero),
    .out_neg(out_neg), .out_ovf(out_ovf)
  );

  // subtractor stage: a + ~b + cin, signed flags only when enabled
  always_comb begin
    {sub_cout, sub_out} = {1'b0, sub_a} + {1'b0, ~sub_b} + {8'd0, sub_cin};
    sub_zero = (sub_out == '0);
    sub_neg  = sub_signed_en & sub_out[W-1];
    sub_ovf  = sub_signed_en & (sub_a[W-1] != sub_b[W-1]) & (sub_out[W-1] != sub_a[W-1]);
  end

  typedef struct {
    logic [N-1:0] diff;
    logic         borrow, zero, neg, ovf;
    time          t_acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   bp_target = 0;
  bit   chk_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    exp_t e;
    int   r;
    e.diff   = a - b;
    e.borrow = (a < b);
    e.zero   = (e.diff == '0);
    e.neg    = s & e.diff[N-1];
    r        = int'($signed(a)) - int'($signed(b));
    e.ovf    = s & ((r > 32767) || (r < -32768));
    e.t_acc  = 0;
    return e;
  endfunction

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input int bp);
    int   n = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      // junk while busy must be ignored
      in_valid  = 1'b1;
      in_a      = N'($urandom);
      in_b      = N'($urandom);
      in_signed = 1'($urandom);
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    bp_target = bp;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    @(posedge clk);
    e = model(a, b, s);
    e.t_acc = $time;
    q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  initial begin : monitor
    bit           seen = 0;
    int           wait_cnt = 0;
    logic [N+3:0] snap = '0;
    exp_t         e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_ready) begin
        chk_ready = 0;
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
      end
      if (!rst_n) begin
        out_ready = 1'b0;
        seen = 0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1;
          wait_cnt = 0;
          snap = {out_diff, out_borrow, out_zero, out_neg, out_ovf};
          if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
          else chk("latency", 32'($time - q[0].t_acc), 32'(3*P + P/2));
        end else begin
          chk("hold_stable", 32'({out_diff, out_borrow, out_zero, out_neg, out_ovf}), 32'(snap));
        end
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (wait_cnt >= bp_target) begin
          out_ready = 1'b1;
          chk_ready = 1;
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("diff",   32'(out_diff),   32'(e.diff));
            chk("borrow", 32'(out_borrow), 32'(e.borrow));
            chk("zero",   32'(out_zero),   32'(e.zero));
            chk("neg",    32'(out_neg),    32'(e.neg));
            chk("ovf",    32'(out_ovf),    32'(e.ovf));
          end
        end else begin
          wait_cnt++;
          out_ready = 1'b0;
        end
      end else begin
        out_ready = 1'b0;
        seen = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_diff"},  32'(out_diff),  32'd0);
    chk({tag, "_flags"},     32'({out_borrow, out_zero, out_neg, out_ovf}), 32'd0);
  endtask

  initial begin : driver
    int n;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    rst_n = 1'b0;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(in_ready), 32'd1);

    do_op(16'h0100, 16'h0001, 1'b0, 0);
    do_op(16'h0000, 16'h0001, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 1);
    do_op(16'h8000, 16'h0001, 1'b0, 0);
    do_op(16'h1234, 16'h1234, 1'b0, 0);
    do_op(16'h1234, 16'h0034, 1'b1, 2);
    do_op(16'hFFFF, 16'h0000, 1'b1, 5);
    for (int i = 0; i < 40; i++)
      do_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // abort mid-operation: reset while word 1 is on the stage
    do_op(16'h5A5A, 16'h1111, 1'b0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("mid_ready_after_release", 32'(in_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("no_out_valid_after_abort", 32'(out_valid), 32'd0);
    end
    do_op(16'h0100, 16'h0001, 1'b0, 0);
    do_op(16'h7FFF, 16'hFFFF, 1'b1, 0);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
